uart_rx_ctrl_fsm: RTL and testbench
===================================

Name: uart_rx_ctrl_fsm

Overview:
Control state machine for the UART receiver, sitting beside the RX datapath (edge/bit counters, sampler, deserializer, parity and stop checkers). It consumes the datapath status outputs and drives its enables. It detects and qualifies the start bit, sequences the data, parity and stop bits, and issues a one-cycle data_valid or error pulse per frame.

Parameters:
data_wd, 8, data bits per frame
bit_count_wd, 3, width of bit_count; must equal clog2(data_wd)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, idle high
PAR_EN  in  1  parity bit present; sampled only in IDLE/DONE
bit_count  in  bit_count_wd  current data-bit index from datapath
edge_count_done  in  1  one-cycle pulse on last oversample edge of a bit
sampling_done  in  1  one-cycle pulse when sampled_bit is valid
sampled_bit  in  1  majority-voted bit value
par_err  in  1  registered parity-check result, held until next check
stp_err  in  1  registered stop-check result, held until next check
edge_cnt_en  out  1  edge counter run; low clears the counter
bit_cnt_en  out  1  bit counter run; low clears the counter
data_samp_en  out  1  sampler enable
deser_en  out  1  deserializer shift enable
par_chk_en  out  1  parity checker enable
stp_chk_en  out  1  stop checker enable
data_valid  out  1  registered; one-cycle pulse, good frame
par_err_flag  out  1  registered; one-cycle pulse, parity error
stp_err_flag  out  1  registered; one-cycle pulse, framing error

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP, DONE. Reset state is IDLE. All three flag outputs reset to 0.
- Enables are Moore decodes of the state:
  - IDLE: all low.
  - START: edge_cnt_en, data_samp_en.
  - DATA: edge_cnt_en, bit_cnt_en, data_samp_en, deser_en.
  - PARITY: edge_cnt_en, data_samp_en, par_chk_en.
  - STOP: edge_cnt_en, data_samp_en, stp_chk_en.
  - DONE: all low.
- IDLE -> START when RX_IN==0. The counters run from the first START cycle.
- START:
  - sampling_done with sampled_bit==1 is a glitch: go to IDLE immediately, with no flag pulse.
  - Otherwise, on edge_count_done go to DATA.
- DATA: on edge_count_done with bit_count==data_wd-1, go to PARITY if the latched PAR_EN==1, else go to STOP. Other edge_count_done pulses stay in DATA.
- PARITY -> STOP on edge_count_done.
- STOP -> DONE on edge_count_done.
- PAR_EN is latched on the IDLE->START and DONE->START transitions. Changes mid-frame have no effect.
- DONE lasts exactly one cycle and evaluates the frame:
  - stp_err=1: stp_err_flag=1.
  - par_err=1 (parity frames only): par_err_flag=1. Both flags may pulse together.
  - Neither error: data_valid=1.
  - The flags are registered, so they are visible the cycle after DONE. That is 1 cycle after the stop-bit edge_count_done plus 1 cycle of register latency.
- DONE -> START if RX_IN==0 (back-to-back frame, no idle cycle required), else DONE -> IDLE.
- par_err is ignored for non-parity frames.
- Simultaneous sampling_done and edge_count_done in START: glitch rejection has priority.
- Sustained break (RX_IN low): each frame completes with stp_err_flag, then restarts from DONE. There is no lockup.
- Asynchronous reset mid-frame: immediately IDLE, flags cleared, enables low, so the datapath counters clear.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared uart_rx_pkg holds the state encoding localparams (3-bit: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, DONE=5).
- No sub-module. Use a single next-state block, a single output-decode block and a flag register block.

Test Plan:
- Frame 0xA5 LSB-first, PAR_EN=1, even parity bit 0, stop 1, prescale 8 in the datapath -> exactly one data_valid pulse, P_DATA=0xA5, no flags.
- Same frame with parity bit forced to 1 -> par_err_flag pulse, data_valid stays 0.
- Frame 0x3C, PAR_EN=0, stop bit driven 0 -> stp_err_flag pulse, no data_valid; FSM then restarts in START because RX_IN is low.
- RX_IN low for 2 oversample edges then high (glitch) -> FSM returns to IDLE after the START sampling_done, no pulses, all enables low.
- Two back-to-back frames 0x55, 0xAA with no idle gap -> two data_valid pulses spaced exactly one frame time apart.
- Assert RST during DATA bit 4 -> all enables 0 in the same cycle. After release, the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: control FSM state encoding.
package uart_rx_pkg;

    localparam int RX_STATE_WD = 3;

    typedef enum logic [RX_STATE_WD-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_fsm.sv
// UART receiver control FSM: qualifies the start bit, sequences data/parity/stop
// bits, drives the datapath enables and pulses one frame-result flag per frame.
module uart_rx_ctrl_fsm
    import uart_rx_pkg::*;
#(
    parameter int data_wd      = 8,
    parameter int bit_count_wd = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RX_IN,
    input  logic                    PAR_EN,
    input  logic [bit_count_wd-1:0] bit_count,
    input  logic                    edge_count_done,
    input  logic                    sampling_done,
    input  logic                    sampled_bit,
    input  logic                    par_err,
    input  logic                    stp_err,
    output logic                    edge_cnt_en,
    output logic                    bit_cnt_en,
    output logic                    data_samp_en,
    output logic                    deser_en,
    output logic                    par_chk_en,
    output logic                    stp_chk_en,
    output logic                    data_valid,
    output logic                    par_err_flag,
    output logic                    stp_err_flag
);

    localparam logic [bit_count_wd-1:0] LAST_BIT = bit_count_wd'(data_wd - 1);

    rx_state_e state;
    rx_state_e next_state;
    logic      par_en_lat;

    // PAR_EN only counts at the moment a frame begins, so mid-frame changes are ignored.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            par_en_lat <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE || state == ST_DONE) && next_state == ST_START) begin
                par_en_lat <= PAR_EN;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!RX_IN) next_state = ST_START;
            end
            ST_START: begin
                // A high mid-bit sample means the falling edge was noise; this beats edge_count_done.
                if (sampling_done && sampled_bit) next_state = ST_IDLE;
                else if (edge_count_done)         next_state = ST_DATA;
            end
            ST_DATA: begin
                if (edge_count_done && bit_count == LAST_BIT) begin
                    next_state = par_en_lat ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (edge_count_done) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (edge_count_done) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = RX_IN ? ST_IDLE : ST_START;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        edge_cnt_en  = 1'b0;
        bit_cnt_en   = 1'b0;
        data_samp_en = 1'b0;
        deser_en     = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;
        case (state)
            ST_START: begin
                edge_cnt_en  = 1'b1;
                data_samp_en = 1'b1;
            end
            ST_DATA: begin
                edge_cnt_en  = 1'b1;
                bit_cnt_en   = 1'b1;
                data_samp_en = 1'b1;
                deser_en     = 1'b1;
            end
            ST_PARITY: begin
                edge_cnt_en  = 1'b1;
                data_samp_en = 1'b1;
                par_chk_en   = 1'b1;
            end
            ST_STOP: begin
                edge_cnt_en  = 1'b1;
                data_samp_en = 1'b1;
                stp_chk_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // DONE lasts one cycle, so each flag is a single-cycle pulse one cycle after DONE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_valid   <= 1'b0;
            par_err_flag <= 1'b0;
            stp_err_flag <= 1'b0;
        end else begin
            data_valid   <= (state == ST_DONE) && !stp_err && !(par_en_lat && par_err);
            par_err_flag <= (state == ST_DONE) && par_en_lat && par_err;
            stp_err_flag <= (state == ST_DONE) && stp_err;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl_fsm.sv
// Bench for uart_rx_ctrl_fsm: frames are expanded into a per-cycle timeline of
// datapath status inputs and the enables/flags the frame rules demand.
module tb_uart_rx_ctrl_fsm;

    localparam int P    = 8;
    localparam int SAMP = 5;

    localparam logic [5:0] EN_NONE  = 6'b000000;
    localparam logic [5:0] EN_START = 6'b101000;
    localparam logic [5:0] EN_DATA  = 6'b111100;
    localparam logic [5:0] EN_PAR   = 6'b101010;
    localparam logic [5:0] EN_STOP  = 6'b101001;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN, PAR_EN;
    logic [2:0] bit_count;
    logic       edge_count_done, sampling_done, sampled_bit, par_err, stp_err;
    logic       edge_cnt_en, bit_cnt_en, data_samp_en, deser_en, par_chk_en, stp_chk_en;
    logic       data_valid, par_err_flag, stp_err_flag;

    uart_rx_ctrl_fsm #(.data_wd(8), .bit_count_wd(3)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .bit_count(bit_count),
        .edge_count_done(edge_count_done), .sampling_done(sampling_done),
        .sampled_bit(sampled_bit), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt_en(edge_cnt_en), .bit_cnt_en(bit_cnt_en), .data_samp_en(data_samp_en),
        .deser_en(deser_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .data_valid(data_valid), .par_err_flag(par_err_flag), .stp_err_flag(stp_err_flag)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       rx;
        logic       par_en;
        logic [2:0] bc;
        logic       ecd;
        logic       sd;
        logic       sb;
        logic       pe;
        logic       se;
        logic       rst;
        logic [5:0] en;
        logic [2:0] fl;
    } rec_t;

    rec_t recs[$];
    rec_t cur;
    logic [2:0] pend = 3'b000;
    logic cur_pe = 1'b0, cur_se = 1'b0;
    int exp_dv_total = 0;
    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    logic chk_valid = 1'b0;
    int dv_cycles[$];
    int pe_seen = 0, se_seen = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s rec=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r        = '0;
        r.rx     = 1'b1;
        r.par_en = 1'($urandom);
        r.sb     = 1'($urandom);
        r.pe     = cur_pe;
        r.se     = cur_se;
        r.en     = EN_NONE;
        return r;
    endfunction

    // The frame result of a DONE cycle shows up on whatever cycle follows it.
    task automatic push(input rec_t r);
        r.fl = pend;
        if (pend[2]) exp_dv_total++;
        pend = 3'b000;
        recs.push_back(r);
    endtask

    task automatic gen_idle(input int n);
        for (int i = 0; i < n; i++) push(idle_rec());
    endtask

    // The line falls on the cycle before START, which is also when PAR_EN is taken.
    task automatic gen_frame(input logic [7:0] data, input logic pen, input logic par_bad,
                             input logic stop_bit, input int glitch_off);
        rec_t r;
        int   nbits, b, o;
        logic bitval;
        logic [5:0] en;
        r        = recs[recs.size()-1];
        r.rx     = 1'b0;
        r.par_en = pen;
        recs[recs.size()-1] = r;
        cur_pe = 1'($urandom);
        cur_se = 1'($urandom);
        if (glitch_off > 0) begin
            for (int k = 0; k <= glitch_off; k++) begin
                r     = idle_rec();
                r.rx  = (k < 2) ? 1'b0 : 1'b1;
                r.ecd = (k == P-1);
                r.sd  = (k == glitch_off);
                if (r.sd) r.sb = 1'b1;
                r.en  = EN_START;
                push(r);
            end
            return;
        end
        nbits = pen ? 11 : 10;
        for (int k = 0; k < nbits*P; k++) begin
            b = k / P;
            o = k % P;
            r = idle_rec();
            if (b == 0) begin
                bitval = 1'b0; en = EN_START;
            end else if (b <= 8) begin
                bitval = data[b-1]; en = EN_DATA; r.bc = 3'(b-1);
            end else if (pen && b == 9) begin
                bitval = (^data) ^ par_bad; en = EN_PAR;
            end else begin
                bitval = stop_bit; en = EN_STOP;
            end
            r.rx  = bitval;
            r.en  = en;
            r.ecd = (o == P-1);
            r.sd  = (o == SAMP);
            if (r.sd) r.sb = bitval;
            if (o == SAMP+1 && en == EN_PAR)  cur_pe = par_bad;
            if (o == SAMP+1 && en == EN_STOP) cur_se = !stop_bit;
            r.pe = cur_pe;
            r.se = cur_se;
            push(r);
        end
        push(idle_rec());
        pend = {!(pen && par_bad) && stop_bit, pen && par_bad, !stop_bit};
    endtask

    task automatic apply_stimulus(input rec_t r, input int idx);
        RX_IN           = r.rx;
        PAR_EN          = r.par_en;
        bit_count       = r.bc;
        edge_count_done = r.ecd;
        sampling_done   = r.sd;
        sampled_bit     = r.sb;
        par_err         = r.pe;
        stp_err         = r.se;
        RST             = !r.rst;
        cur             = r;
        cyc             = idx;
        chk_valid       = 1'b1;
    endtask

    // Single compare point, mid-cycle, against the timeline expectation.
    always @(negedge CLK) begin
        if (chk_valid) begin
            check_output("enables", {26'd0, edge_cnt_en, bit_cnt_en, data_samp_en,
                                     deser_en, par_chk_en, stp_chk_en}, {26'd0, cur.en});
            check_output("flags", {29'd0, data_valid, par_err_flag, stp_err_flag},
                         {29'd0, cur.fl});
            if (data_valid)   dv_cycles.push_back(cyc);
            if (par_err_flag) pe_seen++;
            if (stp_err_flag) se_seen++;
        end
    end

    initial begin
        int n_dir, n_fix, base, g, spacing;
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; bit_count = '0;
        edge_count_done = 1'b0; sampling_done = 1'b0; sampled_bit = 1'b0;
        par_err = 1'b0; stp_err = 1'b0;

        gen_idle(2);
        gen_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0); gen_idle(3);
        gen_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0); gen_idle(3);
        gen_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
        gen_frame(8'h00, 1'b0, 1'b0, 1'b1, 5); gen_idle(4);
        gen_frame(8'h55, 1'b1, 1'b0, 1'b1, 0);
        gen_frame(8'hAA, 1'b1, 1'b0, 1'b1, 0); gen_idle(2);
        gen_frame(8'h00, 1'b0, 1'b0, 1'b1, 7); gen_idle(2);
        gen_frame(8'h00, 1'b1, 1'b1, 1'b0, 0); gen_idle(3);
        n_dir = recs.size();

        base = recs.size();
        gen_frame(8'hF0, 1'b0, 1'b0, 1'b1, 0);
        while (recs.size() > base + 5*P + 3) void'(recs.pop_back());
        pend = 3'b000;
        begin
            rec_t r;
            r     = idle_rec();
            r.rst = 1'b1;
            push(r);
        end
        gen_idle(3);
        gen_frame(8'h81, 1'b0, 1'b0, 1'b1, 0); gen_idle(3);
        n_fix = recs.size();

        for (int f = 0; f < 30; f++) begin
            g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 7)) : 0;
            gen_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 4) != 0), g);
            gen_idle(g > 0 ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)));
        end
        gen_idle(3);

        repeat (3) @(posedge CLK);
        #1;
        check_output("reset_enables", {26'd0, edge_cnt_en, bit_cnt_en, data_samp_en,
                                       deser_en, par_chk_en, stp_chk_en}, 32'd0);
        check_output("reset_flags", {29'd0, data_valid, par_err_flag, stp_err_flag}, 32'd0);
        RST = 1'b1;

        for (int i = 0; i < recs.size(); i++) begin
            @(posedge CLK);
            if (i == n_dir) begin
                check_output("directed_dv_count", dv_cycles.size(), 3);
                check_output("directed_pe_count", pe_seen, 2);
                check_output("directed_se_count", se_seen, 2);
                check_output("first_dv_cycle", (dv_cycles.size() > 0) ? dv_cycles[0] : -1, 91);
                spacing = (dv_cycles.size() >= 3) ? dv_cycles[2] - dv_cycles[1] : -1;
                check_output("back_to_back_spacing", spacing, 89);
            end
            if (i == n_fix) begin
                check_output("post_reset_dv_count", dv_cycles.size(), 4);
            end
            #1;
            apply_stimulus(recs[i], i);
        end
        @(posedge CLK);
        #1;
        chk_valid = 1'b0;
        check_output("total_dv_count", dv_cycles.size(), exp_dv_total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
